// File: rtl/piso_serializer.sv
// Parallel-in/serial-out word serializer with a one-word holding buffer so
// consecutive words stream onto the serial line with no idle bit in between.
//
// state | meaning
// IDLE  | no word in flight, line at IDLE_BIT, next accepted word loads sh directly
// SHIFT | one bit of sh on the line per clock; hold may carry the following word
module piso_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] sh_shifted;

    // Readiness depends only on registered state (and reset), never on load_valid.
    assign load_ready = ~hold_full_q & ~rst;
    assign accept     = load_valid & load_ready;
    assign last_bit   = (cnt_q == CNT_LAST);
    assign sh_shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d    = load_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    // The held word takes priority; load_ready is low then, so no accept can collide.
                    if (hold_full_q) begin
                        sh_d        = hold_q;
                        cnt_d       = '0;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        sh_d  = load_data;
                        cnt_d = '0;
                    end else begin
                        sh_d    = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    sh_d  = sh_shifted;
                    cnt_d = cnt_q + 1'b1;
                    if (accept) begin
                        hold_d      = load_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ser_bit   = IDLE_BIT;
        ser_valid = 1'b0;
        word_done = 1'b0;
        if (state_q == SHIFT) begin
            ser_bit   = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
            ser_valid = 1'b1;
            word_done = last_bit;
        end
    end

    assign busy = (state_q == SHIFT) | hold_full_q;

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out front end for the serial sequence-detector path. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `ser_bit`, which drives the detector's serial data input. A one-word holding buffer lets consecutive words stream with no idle bit between them. Outside words, the line carries a fixed idle level.

## Interface
- `WIDTH`, 8: word width in bits, ≥ 2.
- `MSB_FIRST`, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `IDLE_BIT`, 0: value driven on `ser_bit` when no word is being sent.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `load_data`  in  WIDTH  parallel word.
- `load_valid`  in  1  `load_data` is valid this cycle.
- `load_ready`  out  1  block can accept a word this cycle.
- `ser_bit`  out  1  serial data bit; feeds the detector's `Din`.
- `ser_valid`  out  1  `ser_bit` carries a word bit this cycle.
- `word_done`  out  1  one-cycle pulse during the last bit of each word.
- `busy`  out  1  shifter active or holding buffer occupied.

## Operation
- **Storage:**
  - shift register `sh` (WIDTH bits)
  - bit counter `cnt` (0..WIDTH-1, width clog2(WIDTH))
  - holding register `hold` with flag `hold_full`
- **FSM states:** IDLE, SHIFT.
- **Accept condition:** a word is accepted when `load_valid && load_ready` at a rising edge.
  - `load_ready = !hold_full`. It is driven from a register and has no combinational path from `load_valid`.
- **IDLE + accept:**
  - Word goes directly into `sh`; `cnt` ← 0; next state SHIFT.
  - `hold` stays empty.
- **SHIFT, every edge:**
  - Next bit is presented; `cnt` increments.
  - MSB_FIRST: `sh` shifts left. LSB-first: `sh` shifts right.
- **SHIFT + accept while `cnt` < WIDTH-1:** word goes into `hold`; `hold_full` ← 1.
- **Edge at the end of the last bit (`cnt` = WIDTH-1):**
  - If `hold_full`: `hold` → `sh`, `cnt` ← 0, `hold_full` ← 0, stay in SHIFT. The next word's first bit follows with no gap.
  - Else if an accept happens on the same edge: word goes directly → `sh`, `cnt` ← 0, stay in SHIFT, no gap.
  - Else: go to IDLE.
- **Output values:**
  - `ser_bit` = current output bit of `sh` in SHIFT, `IDLE_BIT` in IDLE.
  - `ser_valid` = (state == SHIFT).
  - `word_done` = SHIFT && `cnt` == WIDTH-1.
  - `busy` = SHIFT || `hold_full`.
- **Accept acknowledgement:** a word offered while `load_ready` = 0 is not captured. The source must hold it until it is accepted.
- **Gaps and the detector:** the detector has no valid input, so bits sent during gaps are `IDLE_BIT`. With `IDLE_BIT` = 0, a gap can extend or break an in-progress detection pattern. This is intended and left to the system integrator.

## Timing
- **Reset (while `rst` = 1, and after release):**
  - state IDLE, `sh` = 0, `cnt` = 0, `hold_full` = 0
  - `ser_bit` = `IDLE_BIT`, `ser_valid` = 0, `word_done` = 0, `busy` = 0
  - `load_ready` = 0 while `rst` is high, 1 from the first cycle after release
- **Reset mid-word:** the current word and any held word are discarded. No further bits of either are emitted.
- **Latency:** accept at edge E in IDLE → first bit valid from E until E+1. The last bit is valid in the cycle after edge E+WIDTH-1.
- **Throughput:** one bit per clock; back-to-back words are gapless as long as each word is accepted before the previous word's last-bit edge.
- **Holding-buffer readiness:**
  - `load_ready` drops the cycle after a word enters `hold`.
  - It rises the cycle after `hold` is transferred to `sh`.
  - There is no accept on the same edge that drains `hold`.
- **Idle gap:** if no word is available at the last-bit edge, there is at least one idle cycle. A new word is then accepted in IDLE, with 1-cycle latency.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-cycle, with no clock edge → all outputs take their reset values immediately. After release, `load_ready` = 1, `ser_bit` = `IDLE_BIT`.
- **Single MSB-first word:** WIDTH = 8, MSB_FIRST = 1, send 8'hA5 → `ser_bit` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with `ser_valid` = 1, `word_done` high only on the 8th cycle, then IDLE.
- **Back-to-back words:** send 8'hAA then 8'h0F with `load_valid` held high → 16 contiguous valid bits 10101010 00001111. `load_ready` is low from the cycle after 8'h0F is captured until `hold` is transferred. `word_done` is high on cycles 8 and 16.
- **LSB-first:** MSB_FIRST = 0, send 8'b0000_0101 → bits 1,0,1,0,0,0,0,0.
- **Reset mid-word:** assert `rst` after 3 bits of 8'hFF with a second word held → output immediately returns to `IDLE_BIT`, `ser_valid` = 0, `busy` = 0. No remaining bits of either word appear after release.
- **End-to-end with the detector:** connect `ser_bit` to the detector's `Din`, send 8'b1010_1010 MSB-first → detector output asserts after the 4th, 6th and 8th serial bits (overlapping 1010 matches).
